// File: rtl/serial_alu_seq_pkg.sv
// serial_alu_seq_pkg: op encodings and FSM state type shared by the serial ALU files
package serial_alu_seq_pkg;
   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam logic [1:0] OP_NOTA = 2'b11;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/alu.sv
// alu: 1-bit ALU slice; overflow is the slice carry-out and is only meaningful for ADD
module alu
   import serial_alu_seq_pkg::*;
(
   input  logic       A,
   input  logic       B,
   input  logic       cin,
   input  logic [1:0] ALUCtrl,
   output logic       S,
   output logic       overflow
);
   always_comb begin
      S = (ALUCtrl == OP_AND) ? (A & B) :
          (ALUCtrl == OP_OR)  ? (A | B) :
          (ALUCtrl == OP_ADD) ? (A ^ B ^ cin) : ~A;
      overflow = (ALUCtrl == OP_ADD) & ((A & B) | (cin & (A ^ B)));
   end
endmodule

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial ALU processing one operand bit per cycle, LSB first
module serial_alu_seq
   import serial_alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d, result_q, result_d;
   logic [1:0]       op_q, op_d;
   logic             carry_q, carry_d, ovf_sh_q, ovf_sh_d, done_q, done_d;
   logic             carry_out_q, carry_out_d, overflow_q, overflow_d;
   logic             s, cout;

   alu u_alu (
      .A       (a_sh_q[0]),
      .B       (b_sh_q[0]),
      .cin     (carry_q),
      .ALUCtrl (op_q),
      .S       (s),
      .overflow(cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         res_sh_q    <= '0;
         result_q    <= '0;
         op_q        <= '0;
         carry_q     <= 1'b0;
         ovf_sh_q    <= 1'b0;
         done_q      <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         res_sh_q    <= res_sh_d;
         result_q    <= result_d;
         op_q        <= op_d;
         carry_q     <= carry_d;
         ovf_sh_q    <= ovf_sh_d;
         done_q      <= done_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
      end
   end

   always_comb begin
      state_d = (state_q == IDLE)  ? (start ? SHIFT : IDLE) :
                (state_q == SHIFT) ? ((cnt_q == LAST) ? DONE : SHIFT) : IDLE;
   end

   always_comb begin
      cnt_d       = cnt_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      res_sh_d    = res_sh_q;
      op_d        = op_q;
      carry_d     = carry_q;
      ovf_sh_d    = ovf_sh_q;
      result_d    = result_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      done_d      = (state_q == DONE);
      if (state_q == IDLE && start) begin
         a_sh_d   = a;
         b_sh_d   = b;
         op_d     = op;
         cnt_d    = '0;
         carry_d  = 1'b0;
         ovf_sh_d = 1'b0;
      end
      if (state_q == SHIFT) begin
         a_sh_d   = a_sh_q >> 1;
         b_sh_d   = b_sh_q >> 1;
         res_sh_d = {s, res_sh_q[WIDTH-1:1]};
         carry_d  = (op_q == OP_ADD) & cout;
         cnt_d    = cnt_q + CW'(1);
         // carry_q here is the carry into the MSB on the final bit
         if (cnt_q == LAST) ovf_sh_d = (op_q == OP_ADD) & (carry_q ^ cout);
      end
      if (state_q == DONE) begin
         result_d    = res_sh_q;
         carry_out_d = carry_q;
         overflow_d  = ovf_sh_q;
      end
   end

   always_comb begin
      busy      = (state_q != IDLE);
      done      = done_q;
      result    = result_q;
      carry_out = carry_out_q;
      overflow  = overflow_q;
   end
endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: randomized and directed checks of serial_alu_seq against an arithmetic model
module tb_serial_alu_seq;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [1:0] op = '0;
   logic       busy, done, carry_out, overflow;
   logic [7:0] result;
   int         tests = 0;
   int         fails = 0;

   serial_alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op),
      .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
      logic [8:0] sum;
      sum = x + y;
      case (o)
         2'b00:   return {2'b00, x & y};
         2'b01:   return {2'b00, x | y};
         2'b10:   return {sum[8], (x[7] == y[7]) && (sum[7] != x[7]), sum[7:0]};
         default: return {2'b00, ~x};
      endcase
   endfunction

   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] iop, output int lat);
      @(negedge clk);
      start = 1'b1; a = ia; b = ib; op = iop;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         if (done) begin
            lat = k - 1;
            break;
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      int k;
      #2;
      tests++;
      if ({busy, done, result, carry_out, overflow} !== 12'h0) begin
         fails++;
         $display("FAIL reset_outputs: got %h expected %h", {busy, done, result, carry_out, overflow}, 12'h0);
      end
      @(negedge clk);
      rst_n = 1'b1; start = 1'b1; a = 8'h03; b = 8'h04; op = 2'b10;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL first_edge_accept: busy got %b expected 1", busy);
      end
      for (k = 0; k < 30 && !done; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
      tests++;
      if ({done, result} !== {1'b1, 8'h07}) begin
         fails++;
         $display("FAIL first_op_result: got %h expected %h", {done, result}, {1'b1, 8'h07});
      end
   endtask

   task automatic test_add_overflow();
      int lat;
      run_op(8'h7F, 8'h01, 2'b10, lat);
      tests++;
      if ({result, carry_out, overflow, busy} !== {8'h80, 1'b0, 1'b1, 1'b0} || lat != 9) begin
         fails++;
         $display("FAIL add_overflow: got res=%h c=%b v=%b busy=%b lat=%0d expected res=80 c=0 v=1 busy=0 lat=9",
                  result, carry_out, overflow, busy, lat);
      end
      @(negedge clk);
      tests++;
      if ({done, result} !== {1'b0, 8'h80}) begin
         fails++;
         $display("FAIL done_single_cycle: got done=%b res=%h expected done=0 res=80", done, result);
      end
   endtask

   task automatic test_carry_clear();
      int lat;
      run_op(8'hFF, 8'h01, 2'b10, lat);
      tests++;
      if ({result, carry_out, overflow} !== {8'h00, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL add_carry: got res=%h c=%b v=%b expected res=00 c=1 v=0", result, carry_out, overflow);
      end
      run_op(8'hF0, 8'h3C, 2'b00, lat);
      tests++;
      if ({result, carry_out, overflow} !== {8'h30, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL and_after_carry: got res=%h c=%b v=%b expected res=30 c=0 v=0", result, carry_out, overflow);
      end
      run_op(8'h00, 8'h00, 2'b10, lat);
      tests++;
      if ({result, carry_out, overflow} !== {8'h00, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL add_zero_after_carry: got res=%h c=%b v=%b expected res=00 c=0 v=0", result, carry_out, overflow);
      end
   endtask

   task automatic test_nota_or();
      int lat;
      run_op(8'h5A, 8'hFF, 2'b11, lat);
      tests++;
      if ({result, carry_out, overflow} !== {8'hA5, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL nota: got res=%h c=%b v=%b expected res=a5 c=0 v=0", result, carry_out, overflow);
      end
      run_op(8'h0F, 8'h50, 2'b01, lat);
      tests++;
      if ({result, carry_out, overflow} !== {8'h5F, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL or: got res=%h c=%b v=%b expected res=5f c=0 v=0", result, carry_out, overflow);
      end
   endtask

   task automatic test_start_ignored();
      int ndone = 0;
      logic [7:0] res_seen = '0;
      @(negedge clk);
      start = 1'b1; a = 8'h01; b = 8'h02; op = 2'b10;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (k == 3) begin
            start = 1'b1; a = 8'hFF;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            ndone++;
            res_seen = result;
         end
      end
      start = 1'b0;
      tests++;
      if (ndone != 1 || res_seen !== 8'h03) begin
         fails++;
         $display("FAIL start_ignored: got dones=%0d res=%h expected dones=1 res=03", ndone, res_seen);
      end
   endtask

   task automatic test_reset_mid_op();
      int ndone = 0;
      int lat;
      @(negedge clk);
      start = 1'b1; a = 8'h11; b = 8'h22; op = 2'b10;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL busy_mid_shift: got %b expected 1", busy);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({busy, done, result, carry_out, overflow} !== 12'h0) begin
         fails++;
         $display("FAIL async_reset: got %h expected %h", {busy, done, result, carry_out, overflow}, 12'h0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) ndone++;
      end
      tests++;
      if (ndone != 0) begin
         fails++;
         $display("FAIL aborted_no_done: got dones=%0d expected 0", ndone);
      end
      run_op(8'h10, 8'h20, 2'b10, lat);
      tests++;
      if ({result, carry_out, overflow} !== {8'h30, 1'b0, 1'b0} || lat != 9) begin
         fails++;
         $display("FAIL after_reset_add: got res=%h c=%b v=%b lat=%0d expected res=30 c=0 v=0 lat=9",
                  result, carry_out, overflow, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] exp_q[$];
      logic [9:0] e;
      int n = 0;
      int prev = -1;
      @(negedge clk);
      start = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      exp_q.push_back(model(a, b, op));
      for (int cyc = 1; cyc <= 100 && n < 5; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            e = exp_q.pop_front();
            tests++;
            if ({carry_out, overflow, result} !== e || (prev < 0 ? cyc != 10 : cyc - prev != 10)) begin
               fails++;
               $display("FAIL back_to_back[%0d]: got c/v/res=%h at cyc %0d (prev %0d) expected %h every 10",
                        n, {carry_out, overflow, result}, cyc, prev, e);
            end
            prev = cyc;
            n++;
            if (n < 5) begin
               a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
               exp_q.push_back(model(a, b, op));
            end
         end
      end
      start = 1'b0;
      tests++;
      if (n != 5) begin
         fails++;
         $display("FAIL back_to_back_count: got %0d dones expected 5", n);
      end
   endtask

   task automatic test_random();
      int lat;
      logic [7:0] x, y;
      logic [1:0] o;
      for (int i = 0; i < 20; i++) begin
         x = 8'($urandom); y = 8'($urandom); o = 2'($urandom);
         run_op(x, y, o, lat);
         tests++;
         if ({carry_out, overflow, result} !== model(x, y, o) || lat != 9) begin
            fails++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h: got c/v/res=%h lat=%0d expected %h lat=9",
                     i, o, x, y, {carry_out, overflow, result}, lat, model(x, y, o));
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_carry_clear();
      test_nota_or();
      test_start_ignored();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
